// File: rtl/mem_port_arbiter.sv
// Two-port read arbiter in front of a single level-handshake memory read port.
// Define MEM_PORT_ARBITER_ROUND_ROBIN_EN for round-robin ties; otherwise port 0 has fixed priority.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_address,
    output logic                  req0_ready,
    output logic                  resp0_valid,
    output logic [DATA_WIDTH-1:0] resp0_data,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_address,
    output logic                  req1_ready,
    output logic                  resp1_valid,
    output logic [DATA_WIDTH-1:0] resp1_data,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_read,
    input  logic [DATA_WIDTH-1:0] mem_value,
    input  logic                  mem_ready,
    output logic                  timeout
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_READ    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    localparam logic       TIMEOUT_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [8:0] TIMEOUT_LIMIT = 9'(TIMEOUT_CYCLES);

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_mem_address;
    logic                  r_mem_read;
    logic                  r_owner;
    logic [7:0]            r_cnt;
    logic                  r_resp0_valid;
    logic                  r_resp1_valid;
    logic [DATA_WIDTH-1:0] r_resp0_data;
    logic [DATA_WIDTH-1:0] r_resp1_data;
    logic                  r_timeout;

    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] w_addr_nxt;
    logic                  w_mem_read_nxt;
    logic                  w_owner_nxt;
    logic [7:0]            w_cnt_nxt;
    logic [7:0]            w_cnt_inc;
    logic                  w_resp0_valid_nxt;
    logic                  w_resp1_valid_nxt;
    logic [DATA_WIDTH-1:0] w_resp0_data_nxt;
    logic [DATA_WIDTH-1:0] w_resp1_data_nxt;
    logic [DATA_WIDTH-1:0] w_ret_data;
    logic                  w_timeout_nxt;
    logic                  w_timeout_hit;
    logic                  w_grant;
    logic                  w_pick1;

`ifdef MEM_PORT_ARBITER_ROUND_ROBIN_EN
    logic r_last;
    logic w_last_nxt;

    // On a tie, the port that was not granted last wins.
    assign w_pick1 = req1_valid && (!req0_valid || !r_last);
`else
    assign w_pick1 = req1_valid && !req0_valid;
`endif

    // A completion still visible from the previous read blocks any new grant.
    assign w_grant    = (r_state == ST_IDLE) && !reset && !mem_ready && (req0_valid || req1_valid);
    assign req0_ready = w_grant && !w_pick1;
    assign req1_ready = w_grant && w_pick1;

    assign w_cnt_inc     = (r_cnt == 8'hFF) ? 8'hFF : (r_cnt + 8'd1);
    assign w_timeout_hit = TIMEOUT_EN && (({1'b0, r_cnt} + 9'd1) >= TIMEOUT_LIMIT);
    assign w_ret_data    = mem_ready ? mem_value : {DATA_WIDTH{1'b0}};

    assign mem_address = r_mem_address;
    assign mem_read    = r_mem_read;
    assign resp0_valid = r_resp0_valid;
    assign resp1_valid = r_resp1_valid;
    assign resp0_data  = r_resp0_data;
    assign resp1_data  = r_resp1_data;
    assign timeout     = r_timeout;

    // Next-state and next-output logic for the read sequencer.
    always_comb begin
        w_state_nxt       = r_state;
        w_addr_nxt        = r_mem_address;
        w_mem_read_nxt    = 1'b0;
        w_owner_nxt       = r_owner;
        w_cnt_nxt         = r_cnt;
        w_resp0_valid_nxt = 1'b0;
        w_resp1_valid_nxt = 1'b0;
        w_resp0_data_nxt  = r_resp0_data;
        w_resp1_data_nxt  = r_resp1_data;
        w_timeout_nxt     = 1'b0;
`ifdef MEM_PORT_ARBITER_ROUND_ROBIN_EN
        w_last_nxt        = r_last;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_grant) begin
                    w_state_nxt    = ST_READ;
                    w_addr_nxt     = w_pick1 ? req1_address : req0_address;
                    w_owner_nxt    = w_pick1;
                    w_mem_read_nxt = 1'b1;
                    w_cnt_nxt      = 8'd0;
`ifdef MEM_PORT_ARBITER_ROUND_ROBIN_EN
                    w_last_nxt     = w_pick1;
`endif
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_READ: begin
                w_cnt_nxt = w_cnt_inc;
                // Completion takes precedence over a timeout on the same edge.
                if (mem_ready || w_timeout_hit) begin
                    w_state_nxt    = ST_RELEASE;
                    w_mem_read_nxt = 1'b0;
                    w_timeout_nxt  = !mem_ready;
                    if (r_owner) begin
                        w_resp1_valid_nxt = 1'b1;
                        w_resp1_data_nxt  = w_ret_data;
                    end else begin
                        w_resp0_valid_nxt = 1'b1;
                        w_resp0_data_nxt  = w_ret_data;
                    end
                end else begin
                    w_state_nxt    = ST_READ;
                    w_mem_read_nxt = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (mem_ready) begin
                    w_state_nxt = ST_RELEASE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_mem_address <= {ADDR_WIDTH{1'b0}};
            r_mem_read    <= 1'b0;
            r_owner       <= 1'b0;
            r_cnt         <= 8'd0;
            r_resp0_valid <= 1'b0;
            r_resp1_valid <= 1'b0;
            r_resp0_data  <= {DATA_WIDTH{1'b0}};
            r_resp1_data  <= {DATA_WIDTH{1'b0}};
            r_timeout     <= 1'b0;
`ifdef MEM_PORT_ARBITER_ROUND_ROBIN_EN
            r_last        <= 1'b1;
`endif
        end else begin
            r_state       <= w_state_nxt;
            r_mem_address <= w_addr_nxt;
            r_mem_read    <= w_mem_read_nxt;
            r_owner       <= w_owner_nxt;
            r_cnt         <= w_cnt_nxt;
            r_resp0_valid <= w_resp0_valid_nxt;
            r_resp1_valid <= w_resp1_valid_nxt;
            r_resp0_data  <= w_resp0_data_nxt;
            r_resp1_data  <= w_resp1_data_nxt;
            r_timeout     <= w_timeout_nxt;
`ifdef MEM_PORT_ARBITER_ROUND_ROBIN_EN
            r_last        <= w_last_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected reads are queued when requests are
// issued and compared when a response pulse appears; a small memory responder drives mem_ready.
module tb_mem_port_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req0_valid = 1'b0;
    logic [31:0] req0_address = 32'd0;
    logic        req0_ready;
    logic        resp0_valid;
    logic [31:0] resp0_data;
    logic        req1_valid = 1'b0;
    logic [31:0] req1_address = 32'd0;
    logic        req1_ready;
    logic        resp1_valid;
    logic [31:0] resp1_data;
    logic [31:0] mem_address;
    logic        mem_read;
    logic [31:0] mem_value = 32'd0;
    logic        mem_ready = 1'b0;
    logic        timeout;

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_address(req0_address), .req0_ready(req0_ready),
        .resp0_valid(resp0_valid), .resp0_data(resp0_data),
        .req1_valid(req1_valid), .req1_address(req1_address), .req1_ready(req1_ready),
        .resp1_valid(resp1_valid), .resp1_data(resp1_data),
        .mem_address(mem_address), .mem_read(mem_read), .mem_value(mem_value),
        .mem_ready(mem_ready), .timeout(timeout)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          port;
        logic [31:0] addr;
        logic [31:0] data;
        bit          tout;
    } exp_t;

    exp_t        sb[$];
    int          resp_cyc[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          mr_cycles = 0;
    bit          mem_auto = 1'b1;
    int          mem_hold = 0;
    int          hold_cnt = 0;
    int          p0_left = 0;
    int          p1_left = 0;
    logic [31:0] p0_addr = 32'd0;
    logic [31:0] p1_addr = 32'd0;
    logic [31:0] p0_step = 32'd0;
    logic [31:0] p1_step = 32'd0;
    logic [31:0] exp_data0 = 32'd0;
    logic [31:0] exp_data1 = 32'd0;

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        return (a == 32'h10) ? 32'h0000_00A5 : ((a * 32'h0101_0101) + 32'h0000_1234);
    endfunction

    always @(posedge clock) cyc <= cyc + 1;

    // Memory responder: answers in the first READ cycle, optionally holds mem_ready afterwards.
    always @(negedge clock) begin
        if (!mem_auto) begin
            mem_ready = 1'b0;
        end else if (mem_read) begin
            mem_ready = 1'b1;
            mem_value = mem_model(mem_address);
            hold_cnt  = mem_hold;
        end else if (mem_ready && hold_cnt > 0) begin
            hold_cnt  = hold_cnt - 1;
        end else begin
            mem_ready = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_rd(input bit port, input logic [31:0] addr, input bit tout);
        exp_t e;
        e.port = port;
        e.addr = addr;
        e.data = tout ? 32'd0 : mem_model(addr);
        e.tout = tout;
        sb.push_back(e);
    endtask

    task automatic do_reset(input int n);
        @(negedge clock);
        reset = 1'b1;
        repeat (n) @(negedge clock);
        reset = 1'b0;
        exp_data0 = 32'd0;
        exp_data1 = 32'd0;
    endtask

    // Drives pending requests, checks every response against the scoreboard.
    task automatic serve(input int budget);
        exp_t e;
        int n;
        n = 0;
        resp_cyc.delete();
        mr_cycles = 0;
        while ((sb.size() > 0 || p0_left > 0 || p1_left > 0) && n < budget) begin
            @(negedge clock);
            req0_valid   = (p0_left > 0);
            req0_address = p0_addr;
            req1_valid   = (p1_left > 0);
            req1_address = p1_addr;
            #1;
            n++;
            if (mem_read) mr_cycles++;
            check("ready_exclusive", {63'd0, req0_ready & req1_ready}, 64'd0);
            if (mem_ready) check("stale_no_grant", {63'd0, req0_ready | req1_ready}, 64'd0);
            if (req0_ready) begin p0_left--; p0_addr = p0_addr + p0_step; end
            if (req1_ready) begin p1_left--; p1_addr = p1_addr + p1_step; end
            if (resp0_valid || resp1_valid) begin
                check("resp_single", {63'd0, resp0_valid & resp1_valid}, 64'd0);
                checks++;
                assert (sb.size() != 0) else begin
                    errors++;
                    $error("FAIL resp_unexpected observed=port%0d expected=none", resp1_valid);
                end
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("resp_port", {63'd0, resp1_valid}, {63'd0, e.port});
                    check("resp_addr", {32'd0, mem_address}, {32'd0, e.addr});
                    check("resp_timeout", {63'd0, timeout}, {63'd0, e.tout});
                    check("resp_mem_read", {63'd0, mem_read}, 64'd0);
                    if (e.port) exp_data1 = e.data; else exp_data0 = e.data;
                    resp_cyc.push_back(cyc);
                end
            end else begin
                check("timeout_quiet", {63'd0, timeout}, 64'd0);
            end
            check("resp0_data", {32'd0, resp0_data}, {32'd0, exp_data0});
            check("resp1_data", {32'd0, resp1_data}, {32'd0, exp_data1});
        end
        checks++;
        assert (sb.size() == 0 && p0_left == 0 && p1_left == 0) else begin
            errors++;
            $error("FAIL serve_budget observed=%0d pending expected=0", sb.size() + p0_left + p1_left);
        end
        sb.delete();
        p0_left = 0;
        p1_left = 0;
        @(negedge clock);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    initial begin
        // Reset values, with a request held during reset that must not be accepted.
        req0_valid = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        check("rst_mem_read", {63'd0, mem_read}, 64'd0);
        check("rst_mem_address", {32'd0, mem_address}, 64'd0);
        check("rst_resp_valid", {62'd0, resp0_valid, resp1_valid}, 64'd0);
        check("rst_resp_data", {resp0_data, resp1_data}, 64'd0);
        check("rst_timeout", {63'd0, timeout}, 64'd0);
        check("rst_ready", {62'd0, req0_ready, req1_ready}, 64'd0);
        req0_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;

        // Port 0 alone, address 0x10 returns 0xA5.
        p0_left = 1; p0_addr = 32'h10; p0_step = 32'd0;
        expect_rd(1'b0, 32'h10, 1'b0);
        serve(50);
        check("single_read_len", 64'(mr_cycles), 64'd1);

        // Contention: port 0 keeps re-presenting, port 1 waits.
        do_reset(2);
        p0_left = 3; p0_addr = 32'h4; p0_step = 32'd0;
        p1_left = 2; p1_addr = 32'h8; p1_step = 32'd0;
`ifdef MEM_PORT_ARBITER_ROUND_ROBIN_EN
        expect_rd(1'b0, 32'h4, 1'b0); expect_rd(1'b1, 32'h8, 1'b0);
        expect_rd(1'b0, 32'h4, 1'b0); expect_rd(1'b1, 32'h8, 1'b0);
        expect_rd(1'b0, 32'h4, 1'b0);
`else
        expect_rd(1'b0, 32'h4, 1'b0); expect_rd(1'b0, 32'h4, 1'b0);
        expect_rd(1'b0, 32'h4, 1'b0); expect_rd(1'b1, 32'h8, 1'b0);
        expect_rd(1'b1, 32'h8, 1'b0);
`endif
        serve(200);

        // Memory never answers: timeout after four READ cycles.
        mem_auto = 1'b0;
        p0_left = 1; p0_addr = 32'h20; p0_step = 32'd0;
        expect_rd(1'b0, 32'h20, 1'b1);
        serve(50);
        check("timeout_read_len", 64'(mr_cycles), 64'd4);
        mem_auto = 1'b1;

        // mem_ready held three cycles after completion delays the next grant.
        mem_hold = 3;
        p0_left = 1; p0_addr = 32'h40; p0_step = 32'd0;
        p1_left = 1; p1_addr = 32'h44; p1_step = 32'd0;
`ifdef MEM_PORT_ARBITER_ROUND_ROBIN_EN
        expect_rd(1'b1, 32'h44, 1'b0); expect_rd(1'b0, 32'h40, 1'b0);
`else
        expect_rd(1'b0, 32'h40, 1'b0); expect_rd(1'b1, 32'h44, 1'b0);
`endif
        serve(100);
        mem_hold = 0;
        if (resp_cyc.size() == 2) check("stale_gap", 64'(resp_cyc[1] - resp_cyc[0]), 64'd6);
        else check("stale_resp_count", 64'(resp_cyc.size()), 64'd2);

        // Reset during READ discards the transaction.
        mem_auto = 1'b0;
        repeat (8) @(negedge clock);
        req0_valid = 1'b1; req0_address = 32'h30;
        #1;
        check("rst_rd_accept", {63'd0, req0_ready}, 64'd1);
        @(negedge clock);
        req0_valid = 1'b0;
        #1;
        check("rst_rd_mem_read", {63'd0, mem_read}, 64'd1);
        check("rst_rd_addr", {32'd0, mem_address}, 64'h30);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        #1;
        check("rst_rd_drop", {63'd0, mem_read}, 64'd0);
        check("rst_rd_no_resp", {61'd0, resp0_valid, resp1_valid, timeout}, 64'd0);
        check("rst_rd_vals", {resp0_data, resp1_data}, 64'd0);
        check("rst_rd_address", {32'd0, mem_address}, 64'd0);
        @(negedge clock);
        #1;
        check("rst_rd_no_resp2", {62'd0, resp0_valid, resp1_valid}, 64'd0);
        reset = 1'b0;
        exp_data0 = 32'd0;
        exp_data1 = 32'd0;
        mem_auto = 1'b1;
        p0_left = 1; p0_addr = 32'h30; p0_step = 32'd0;
        expect_rd(1'b0, 32'h30, 1'b0);
        serve(50);

        // Back-to-back port 1 reads with an instant memory.
        repeat (3) @(negedge clock);
        p1_left = 4; p1_addr = 32'h100; p1_step = 32'd4;
        for (int i = 0; i < 4; i++) expect_rd(1'b1, 32'h100 + 32'(4 * i), 1'b0);
        serve(100);
        if (resp_cyc.size() == 4) begin
            for (int i = 1; i < 4; i++) check("b2b_gap", 64'(resp_cyc[i] - resp_cyc[i-1]), 64'd3);
        end else begin
            check("b2b_resp_count", 64'(resp_cyc.size()), 64'd4);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
